// File: rtl/button_event_fsm_pkg.sv
// button_event_fsm_pkg: shared FSM state type, default limits and sizing helper
package button_event_fsm_pkg;
  typedef enum logic [1:0] {LOCKOUT = 2'd0, IDLE = 2'd1, PRESSED = 2'd2, LONG = 2'd3} state_e;
  localparam int DEF_LONG_PRESS_LIMIT = 12500000;
  localparam int DEF_REPEAT_LIMIT = 2500000;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/button_event_fsm_if.sv
// button_event_fsm_if: button level plus the rise/fall pulses derived from it
interface button_event_fsm_if;
  logic sw;
  logic rise;
  logic fall;
  modport master (input sw, output rise, output fall);
  modport slave (output sw, input rise, input fall);
endinterface

// File: rtl/button_edge_det.sv
// button_edge_det: rise/fall pulses of the button level against its registered previous sample
module button_edge_det (
  input logic i_Clk,
  input logic i_Rst_n,
  button_event_fsm_if.master ev
);
  logic prev_q, prev_d;
  always_comb prev_d = ev.sw;
  always_ff @(posedge i_Clk) prev_q <= !i_Rst_n ? 1'b0 : prev_d;
  assign ev.rise = ev.sw & ~prev_q;
  assign ev.fall = ~ev.sw & prev_q;
endmodule

// File: rtl/button_event_fsm.sv
// button_event_fsm: press/release/long/held/step events from a debounced button
// AUTO_REPEAT_EN defined: o_Step repeats every c_REPEAT_LIMIT cycles while in LONG.
module button_event_fsm
  import button_event_fsm_pkg::*;
#(
  parameter int c_LONG_PRESS_LIMIT = DEF_LONG_PRESS_LIMIT,
  parameter int c_REPEAT_LIMIT = DEF_REPEAT_LIMIT
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Switch,
  output logic o_Press,
  output logic o_Release,
  output logic o_Long,
  output logic o_Held,
  output logic o_Step
);
  localparam int CW = $clog2(max_int(c_LONG_PRESS_LIMIT, c_REPEAT_LIMIT) + 1);
  button_event_fsm_if ev ();
  assign ev.sw = i_Switch;
  button_edge_det u_edge (.i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .ev(ev));
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic press_q, press_d, rel_q, rel_d, long_q, long_d, held_q, held_d, step_q, step_d;
  // IDLE is only entered after a low sample and PRESSED/LONG after a high one,
  // so the edge pulses are exactly the level changes each state cares about.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    press_d = 1'b0;
    rel_d = 1'b0;
    long_d = 1'b0;
    step_d = 1'b0;
    case (state_q)
      LOCKOUT: state_d = !ev.sw ? IDLE : LOCKOUT;
      IDLE: if (ev.rise) begin
        state_d = PRESSED;
        press_d = 1'b1;
        step_d = 1'b1;
        cnt_d = '0;
      end
      PRESSED: if (ev.fall) begin
        state_d = IDLE;
        rel_d = 1'b1;
        cnt_d = '0;
      end else if (cnt_q == CW'(c_LONG_PRESS_LIMIT - 1)) begin
        state_d = LONG;
        long_d = 1'b1;
        cnt_d = '0;
      end else cnt_d = cnt_q + CW'(1);
      LONG: if (ev.fall) begin
        state_d = IDLE;
        rel_d = 1'b1;
        cnt_d = '0;
      end else begin
`ifdef AUTO_REPEAT_EN
        step_d = cnt_q == CW'(c_REPEAT_LIMIT - 1);
        cnt_d = step_d ? '0 : cnt_q + CW'(1);
`else
        cnt_d = '0;
`endif
      end
      default: state_d = LOCKOUT;
    endcase
    held_d = state_d == PRESSED || state_d == LONG;
  end
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q <= LOCKOUT;
      cnt_q <= '0;
      press_q <= 1'b0;
      rel_q <= 1'b0;
      long_q <= 1'b0;
      held_q <= 1'b0;
      step_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      press_q <= press_d;
      rel_q <= rel_d;
      long_q <= long_d;
      held_q <= held_d;
      step_q <= step_d;
    end
  end
  assign o_Press = press_q;
  assign o_Release = rel_q;
  assign o_Long = long_q;
  assign o_Held = held_q;
  assign o_Step = step_q;
endmodule
